// File: rtl/alu_pipe_responder_if.sv
// Request/response channel bundle for alu_pipe_responder.
// master = initiator side, slave = responder side.
interface alu_pipe_responder_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_zero;
  logic             rsp_ex;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_zero, rsp_ex, rsp_tag, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_zero, rsp_ex, rsp_tag, busy
  );
endinterface

// File: rtl/alu_pipe_responder.sv
// 2-stage ALU (AND/OR/ADD/SUB/SLT) with credit-limited request intake and an
// in-order response FIFO.
module alu_pipe_responder #(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  alu_pipe_responder_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             zero;
    logic             ex;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [2:1]       vld_pipe;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  rsp_t             s2_d, s2_q, head;
  rsp_t             mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [CW-1:0]    occ;
  logic             accept, push, pop;

  // Every in-flight request already owns a FIFO slot, so S2 can always push.
  assign occ    = CW'(vld_pipe[1]) + CW'(vld_pipe[2]) + CW'(count);
  assign accept = bus.req_valid && bus.req_ready;
  assign push   = vld_pipe[2];
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  assign bus.req_ready = !reset && (occ < CW'(FIFO_DEPTH));
  assign bus.busy      = !reset && (occ != '0);
  assign bus.rsp_valid = !reset && (count != '0);

  assign head         = mem[rd_ptr];
  assign bus.rsp_z    = bus.rsp_valid ? head.z    : '0;
  assign bus.rsp_zero = bus.rsp_valid ? head.zero : 1'b0;
  assign bus.rsp_ex   = bus.rsp_valid ? head.ex   : 1'b0;
  assign bus.rsp_tag  = bus.rsp_valid ? head.tag  : '0;

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[1], accept};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= bus.req_a;
      s1_b   <= bus.req_b;
      s1_op  <= bus.req_op;
      s1_tag <= bus.req_tag;
    end
    if (vld_pipe[1]) s2_q <= s2_d;
  end

  always_comb begin
    s2_d     = '0;
    s2_d.tag = s1_tag;
    case (s1_op)
      3'b000:  s2_d.z = s1_a & s1_b;
      3'b001:  s2_d.z = s1_a | s1_b;
      3'b010:  s2_d.z = s1_a + s1_b;
      3'b110:  s2_d.z = s1_a + ~s1_b + WIDTH'(1);
      3'b111:  s2_d.z = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: s2_d.ex = 1'b1;
    endcase
    s2_d.zero = (s2_d.z == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && count == (PW+1)'(FIFO_DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && count == '0));
endmodule

// File: tb/tb_alu_pipe_responder.sv
// Scoreboard bench for alu_pipe_responder: accepts push expectations, pops
// are compared in order; scenario tasks add inline latency/flow checks.
module tb_alu_pipe_responder;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             zero;
    logic             ex;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   cyc = 0;
  int   last_pop = -1;
  int   gap_max = 0;
  exp_t sb[$];

  alu_pipe_responder_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) intf ();

  alu_pipe_responder #(.WIDTH(WIDTH), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (intf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [3:0] tag);
    exp_t e;
    e = '0;
    e.tag = tag;
    case (op)
      3'b000: e.z = a & b;
      3'b001: e.z = a | b;
      3'b010: e.z = a + b;
      3'b110: e.z = a - b;
      3'b111: e.z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.ex = 1'b1;
    endcase
    e.zero = (e.z == 32'd0);
    return e;
  endfunction

  // Monitor: handshakes seen at negedge complete on the following posedge.
  bit   hold = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t got, e;
    got = {intf.rsp_z, intf.rsp_zero, intf.rsp_ex, intf.rsp_tag};
    if (reset) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold && intf.rsp_valid) begin
        checks++;
        if (got !== held) begin
          failures++;
          $display("FAIL head_stable got=%h exp=%h", got, held);
        end
      end
      hold = intf.rsp_valid && !intf.rsp_ready;
      held = got;
      if (intf.rsp_valid && intf.rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got tag=%0d z=%h", intf.rsp_tag, intf.rsp_z);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL rsp_match got z=%h zero=%b ex=%b tag=%0d exp z=%h zero=%b ex=%b tag=%0d",
                     got.z, got.zero, got.ex, got.tag, e.z, e.zero, e.ex, e.tag);
          end
        end
        pops++;
        if (last_pop >= 0 && cyc - last_pop > gap_max) gap_max = cyc - last_pop;
        last_pop = cyc;
      end
      if (intf.req_valid && intf.req_ready)
        sb.push_back(model(intf.req_a, intf.req_b, intf.req_op, intf.req_tag));
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [3:0] tag);
    bit ok;
    ok = 1'b0;
    intf.req_valid = 1'b1;
    intf.req_a = a; intf.req_b = b; intf.req_op = op; intf.req_tag = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (intf.req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    intf.req_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout tag=%0d got no ready, exp ready", tag);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!intf.busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout busy=%b pending=%0d exp busy=0 pending=0", intf.busy, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    intf.req_valid = 1'b0; intf.req_a = '0; intf.req_b = '0;
    intf.req_op = '0; intf.req_tag = '0; intf.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({intf.req_ready, intf.rsp_valid, intf.busy, intf.rsp_zero, intf.rsp_ex} !== 5'b0 ||
        intf.rsp_z !== 32'd0 || intf.rsp_tag !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b z=%h tag=%0d exp all 0",
               intf.req_ready, intf.rsp_valid, intf.busy, intf.rsp_z, intf.rsp_tag);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (intf.req_ready !== 1'b1 || intf.busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b busy=%b exp rdy=1 busy=0", intf.req_ready, intf.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    drive_req(32'd5, 32'd3, 3'b010, 4'd1);
    @(posedge clk); #1;
    checks++;
    if (intf.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got rsp_valid=%b exp 0 after 1 edge", intf.rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (intf.rsp_valid !== 1'b1 || intf.rsp_z !== 32'd8 || intf.rsp_zero !== 1'b0 ||
        intf.rsp_ex !== 1'b0 || intf.rsp_tag !== 4'd1) begin
      failures++;
      $display("FAIL latency_rsp got v=%b z=%h zero=%b ex=%b tag=%0d exp v=1 z=8 zero=0 ex=0 tag=1",
               intf.rsp_valid, intf.rsp_z, intf.rsp_zero, intf.rsp_ex, intf.rsp_tag);
    end
    wait_idle();
  endtask

  task automatic test_arith();
    logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hF0F0_00FF};
    logic [31:0] vb [6] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0FF0_0F0F};
    logic [2:0]  vo [6] = '{3'b111, 3'b110, 3'b111, 3'b010, 3'b011, 3'b000};
    logic [31:0] vz [6] = '{32'h1, 32'hFFFF_FFFE, 32'h0, 32'h8000_0000, 32'h0, 32'h00F0_000F};
    logic        vzr[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vex[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_req(va[i], vb[i], vo[i], 4'(i + 2));
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_z !== vz[i] || intf.rsp_zero !== vzr[i] ||
          intf.rsp_ex !== vex[i] || intf.rsp_tag !== 4'(i + 2)) begin
        failures++;
        $display("FAIL arith_%0d got v=%b z=%h zero=%b ex=%b exp z=%h zero=%b ex=%b",
                 i, intf.rsp_valid, intf.rsp_z, intf.rsp_zero, intf.rsp_ex, vz[i], vzr[i], vex[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int acc, t, p0;
    acc = 0; t = 0; p0 = pops;
    intf.rsp_ready = 1'b0;
    intf.req_valid = 1'b1;
    intf.req_a = 32'd100; intf.req_b = 32'd0; intf.req_op = 3'b010; intf.req_tag = 4'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (intf.req_ready) begin
        acc++; t++;
        @(posedge clk); #1;
        intf.req_a = 32'(100 + t); intf.req_tag = 4'(t);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    checks++;
    if (acc != 4 || intf.req_ready !== 1'b0 || intf.busy !== 1'b1) begin
      failures++;
      $display("FAIL credit_limit got acc=%0d rdy=%b busy=%b exp acc=4 rdy=0 busy=1",
               acc, intf.req_ready, intf.busy);
    end
    @(posedge clk); #1;
    intf.rsp_ready = 1'b1;
    for (int k = t; k < 6; k++) drive_req(32'(100 + k), 32'd0, 3'b010, 4'(k));
    wait_idle();
    checks++;
    if (pops - p0 != 6) begin
      failures++;
      $display("FAIL bp_count got %0d responses exp 6", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    int p0;
    p0 = pops;
    last_pop = -1; gap_max = 0;
    intf.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      intf.req_valid = 1'b1;
      intf.req_a = $urandom; intf.req_b = $urandom;
      intf.req_op = ops[$urandom_range(0, 4)]; intf.req_tag = 4'(i);
      @(negedge clk);
      checks++;
      if (intf.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready i=%0d got rdy=%b exp 1", i, intf.req_ready);
      end
      @(posedge clk); #1;
    end
    intf.req_valid = 1'b0;
    wait_idle();
    checks++;
    if (pops - p0 != 16 || gap_max != 1) begin
      failures++;
      $display("FAIL b2b_stream got n=%0d gap=%0d exp n=16 gap=1", pops - p0, gap_max);
    end
  endtask

  task automatic test_reset_midflight();
    int p0;
    intf.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      intf.req_valid = 1'b1;
      intf.req_a = 32'(i); intf.req_b = 32'd1; intf.req_op = 3'b010; intf.req_tag = 4'(i + 1);
      @(posedge clk); #1;
    end
    intf.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (intf.rsp_valid !== 1'b0 || intf.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_during got v=%b rdy=%b exp 0 0", intf.rsp_valid, intf.req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (intf.rsp_valid !== 1'b0 || intf.busy !== 1'b0 || intf.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_after got v=%b busy=%b rdy=%b exp 0 0 1",
               intf.rsp_valid, intf.busy, intf.req_ready);
    end
    @(posedge clk); #1;
    intf.rsp_ready = 1'b1;
    p0 = pops;
    drive_req(32'd20, 32'd22, 3'b010, 4'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (intf.rsp_valid !== 1'b1 || intf.rsp_tag !== 4'd9 || intf.rsp_z !== 32'd42) begin
      failures++;
      $display("FAIL midreset_new got v=%b tag=%0d z=%h exp v=1 tag=9 z=2a",
               intf.rsp_valid, intf.rsp_tag, intf.rsp_z);
    end
    wait_idle();
    checks++;
    if (pops - p0 != 1) begin
      failures++;
      $display("FAIL midreset_count got %0d responses exp 1", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
